pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Pre-IF next-PC generator for the MIPS core. Holds the architectural fetch PC and computes the next PC from four sources: sequential +4, branch/jump redirect, a branch redirect held over a stall, and exception/ERET flush target. Drives pre_pc / pre_exception_type straight into the pre-IF→IF pipeline register. Stall and flush come from the same control unit that drives that register.

Parameters:
RESET_PC, 32'hBFC00000, fetch address loaded on reset
ADEL_MASK, 32'h00000010, value driven on pre_exception_type when fetch address is misaligned

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  1 = hold PC (same stall fed to the pre-IF→IF register)
flush  input  1  exception/ERET redirect, overrides stall
flush_pc  input  32  redirect target valid with flush
branch_flag  input  1  taken branch/jump resolved in ID (delay slot already issued)
branch_target  input  32  target valid with branch_flag
pre_pc  output  32  current fetch PC
pre_exception_type  output  32  fetch exception code for pre_pc

Behaviour:
- State: pc_q[31:0], pend_valid, pend_target[31:0]. FSM states: IDLE (pend_valid=0) and PEND (pend_valid=1).
- Reset, asynchronous on rst=1: pc_q=RESET_PC, pend_valid=0, pend_target=0. After reset: pre_pc=32'hBFC00000 and pre_exception_type=0.
- pre_pc = pc_q, combinational from the register with zero added logic.
- pre_exception_type = ADEL_MASK if pc_q[1:0]!=2'b00, else 0. Combinational from pc_q.
- Next-state priority on each rising edge, highest first:
  1. flush=1: pc_q<=flush_pc; pend_valid<=0. Applies regardless of stall and branch_flag.
  2. stall=1 and branch_flag=1: pc_q holds; pend_target<=branch_target; pend_valid<=1. A new branch overwrites an existing pending target.
  3. stall=1, no branch: all state holds.
  4. stall=0 and branch_flag=1: pc_q<=branch_target; pend_valid<=0. A current branch beats a pending one.
  5. stall=0 and pend_valid=1: pc_q<=pend_target; pend_valid<=0.
  6. Otherwise: pc_q<=pc_q+32'd4, modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
- FSM transitions: IDLE→PEND on rule 2. PEND→IDLE on rules 1, 4 or 5. PEND stays PEND on rules 2 and 3.
- Redirect latency: with stall=0, a branch or flush sampled on edge N makes pre_pc equal the target immediately after edge N.
- Misaligned PC: the ADEL code is reported, but the PC still advances or redirects per the rules above. Downstream flush cancels the wrong-path fetches. There is no internal lockup.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. Any pending redirect is lost.
- branch_target and flush_pc are ignored when their qualifiers are 0.

Test Plan:
- Reset, then run 3 cycles with stall=0 → pre_pc goes BFC00000, BFC00004, BFC00008, BFC0000C; pre_exception_type=0 throughout.
- branch_flag=1, branch_target=0xBFC00100, stall=0 → next cycle pre_pc=0xBFC00100, then 0xBFC00104.
- Branch arrives during stall: stall=1 for 3 cycles, branch_flag pulsed 1 cycle with 0x80001000 → pre_pc held throughout; first unstalled edge gives 0x80001000, next edge 0x80001004.
- flush=1, flush_pc=0xBFC00380, with stall=1 and a pending branch present → pre_pc=0xBFC00380 next cycle; pending branch is dropped (next is 0xBFC00384).
- branch_target=0xBFC00102 → pre_pc=0xBFC00102 with pre_exception_type=0x00000010; next cycle pre_pc=0xBFC00106, still 0x10. Then flush to 0xBFC00380 → exception type returns to 0.
- Force pc_q to 0xFFFFFFFC via flush, then unstalled edge → pre_pc=0x00000000. Assert rst asynchronously mid-cycle while PEND → pre_pc=0xBFC00000 at once; PEND cleared.

Source files
------------

// File: rtl/pc_gen_if.sv
// pc_gen_if: control inputs and fetch-PC outputs of the pre-IF next-PC generator
interface pc_gen_if;
  logic stall;
  logic flush;
  logic [31:0] flush_pc;
  logic branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pre_pc;
  logic [31:0] pre_exception_type;
  modport master (
    output stall, flush, flush_pc, branch_flag, branch_target,
    input pre_pc, pre_exception_type
  );
  modport slave (
    input stall, flush, flush_pc, branch_flag, branch_target,
    output pre_pc, pre_exception_type
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with sequential, branch, held-branch and flush redirect sources
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] ADEL_MASK = 32'h00000010
) (
  input logic clk,
  input logic rst,
  pc_gen_if.slave bus
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_d;
  logic [31:0] pc_q, pc_d, pend_target, pend_target_d;
  logic hold_branch;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_q <= RESET_PC;
      pend_target <= '0;
    end else begin
      state <= state_d;
      pc_q <= pc_d;
      pend_target <= pend_target_d;
    end
  end
  always_comb begin
    hold_branch = !bus.flush && bus.stall && bus.branch_flag;
    pend_target_d = hold_branch ? bus.branch_target : pend_target;
    state_d = bus.flush ? IDLE : bus.stall ? (bus.branch_flag ? PEND : state) : IDLE;
    pc_d = bus.flush ? bus.flush_pc :
           bus.stall ? pc_q :
           bus.branch_flag ? bus.branch_target :
           (state == PEND) ? pend_target : pc_q + 32'd4;
  end
  assign bus.pre_pc = pc_q;
  assign bus.pre_exception_type = (pc_q[1:0] != 2'b00) ? ADEL_MASK : '0;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  pc_gen_if bus();
  pc_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic st, input logic fl, input logic [31:0] fpc,
                     input logic br, input logic [31:0] bt, input logic [31:0] exp_pc);
    logic [63:0] e;
    bus.stall = st;
    bus.flush = fl;
    bus.flush_pc = fpc;
    bus.branch_flag = br;
    bus.branch_target = bt;
    sb.push_back({exp_pc, (exp_pc[1:0] != 2'b00) ? 32'h10 : 32'h0});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pre_pc", bus.pre_pc, e[63:32]);
    chk("exc", bus.pre_exception_type, e[31:0]);
  endtask
  initial begin
    bus.stall = 0;
    bus.flush = 0;
    bus.flush_pc = '0;
    bus.branch_flag = 0;
    bus.branch_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("reset_pc", bus.pre_pc, 32'hBFC00000);
    chk("reset_exc", bus.pre_exception_type, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'hBFC00004);
    cyc(0, 0, 0, 0, 0, 32'hBFC00008);
    cyc(0, 0, 0, 0, 0, 32'hBFC0000C);
    cyc(0, 0, 0, 1, 32'hBFC00100, 32'hBFC00100);
    cyc(0, 0, 0, 0, 0, 32'hBFC00104);
    cyc(1, 0, 0, 1, 32'h80001000, 32'hBFC00104);
    cyc(1, 0, 0, 0, 32'h12121212, 32'hBFC00104);
    cyc(1, 0, 0, 0, 0, 32'hBFC00104);
    cyc(0, 0, 0, 0, 0, 32'h80001000);
    cyc(0, 0, 0, 0, 0, 32'h80001004);
    cyc(1, 0, 0, 1, 32'h12345678, 32'h80001004);
    cyc(1, 1, 32'hBFC00380, 0, 0, 32'hBFC00380);
    cyc(0, 0, 0, 0, 0, 32'hBFC00384);
    cyc(1, 0, 0, 1, 32'h11110000, 32'hBFC00384);
    cyc(0, 0, 0, 1, 32'h22220000, 32'h22220000);
    cyc(0, 0, 0, 0, 0, 32'h22220004);
    cyc(1, 0, 0, 1, 32'hAAAA0000, 32'h22220004);
    cyc(1, 0, 0, 1, 32'hBBBB0000, 32'h22220004);
    cyc(0, 0, 0, 0, 0, 32'hBBBB0000);
    cyc(0, 0, 0, 1, 32'hBFC00102, 32'hBFC00102);
    cyc(0, 0, 0, 0, 0, 32'hBFC00106);
    cyc(0, 1, 32'hBFC00380, 0, 0, 32'hBFC00380);
    cyc(0, 1, 32'hFFFFFFFC, 1, 32'h55555550, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 32'h00000000);
    cyc(0, 0, 0, 0, 0, 32'h00000004);
    cyc(0, 0, 32'hDEADBEEF, 0, 32'hCAFEBABC, 32'h00000008);
    cyc(1, 0, 0, 1, 32'h80002000, 32'h00000008);
    bus.branch_flag = 0;
    #2;
    rst = 1;
    #1;
    chk("async_rst_pc", bus.pre_pc, 32'hBFC00000);
    chk("async_rst_exc", bus.pre_exception_type, 32'h0);
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 0, 0, 0, 32'hBFC00004);
    cyc(0, 0, 0, 0, 0, 32'hBFC00008);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
